dino_jump_fsm: RTL and testbench



---
 rtl/dino_jump_fsm.sv | 135 +++++++++++++
 tb/tb_dino_jump_fsm.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dino_jump_fsm.sv
// Tick-paced dino jump FSM driving a ROWS x COLS one-hot sprite grid.
// Define JUMP_BUFFER_EN to buffer a press made while falling into a back-to-back jump.
module dino_jump_fsm #(
  parameter int unsigned COLS      = 8,
  parameter int unsigned ROWS      = 2,
  parameter int unsigned DINO_COL  = 0,
  parameter int unsigned JUMP_HOLD = 2,
  parameter int unsigned TICK_DIV  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    jump_button,
  output logic [ROWS*COLS-1:0]    grid,
  output logic [$clog2(ROWS)-1:0] height,
  output logic                    airborne,
  output logic                    tick,
  output logic [7:0]              jump_count
);

  localparam int unsigned HW = $clog2(ROWS);
  localparam int unsigned GW = ROWS * COLS;
  localparam int unsigned DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = (JUMP_HOLD > 1) ? $clog2(JUMP_HOLD) : 1;

  localparam logic [HW-1:0] TOP       = HW'(ROWS - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(JUMP_HOLD - 1);
  localparam logic [GW-1:0] GRID_ONE  = GW'(1);

  localparam logic [1:0] GROUND = 2'd0;
  localparam logic [1:0] RISE   = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;
  localparam logic [1:0] FALL   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [HW-1:0] height_q, height_d;
  logic [CW-1:0] hold_q, hold_d;
  logic [7:0]    count_q, count_d;
  logic          pending_q, pending_d;
  logic [DW-1:0] div_q, div_d;
  logic          meta_q, sync_q, sync_prev_q;
  logic          jump_edge;
  logic          request;

  always_comb begin
    tick      = (div_q == DIV_LAST);
    div_d     = tick ? '0 : div_q + DW'(1);
    jump_edge = sync_q & ~sync_prev_q;
    request   = pending_q | jump_edge;
  end

  always_comb begin
    state_d   = state_q;
    height_d  = height_q;
    hold_d    = hold_q;
    count_d   = count_q;
    pending_d = pending_q;

    if (jump_edge && (state_q == GROUND)) pending_d = 1'b1;
`ifdef JUMP_BUFFER_EN
    // Buffered press survives landing and fires on the first grounded tick.
    if (jump_edge && (state_q == FALL)) pending_d = 1'b1;
`endif

    if (tick) begin
      case (state_q)
        GROUND: begin
          if (request) begin
            height_d  = HW'(1);
            hold_d    = '0;
            pending_d = 1'b0;
            state_d   = (ROWS == 2) ? HOLD : RISE;
            if (count_q != 8'hFF) count_d = count_q + 8'd1;
          end
        end
        RISE: begin
          height_d = height_q + HW'(1);
          if (height_d == TOP) begin
            state_d = HOLD;
            hold_d  = '0;
          end
        end
        HOLD: begin
          if (hold_q == HOLD_LAST) begin
            height_d = height_q - HW'(1);
            state_d  = (height_d == '0) ? GROUND : FALL;
          end else begin
            hold_d = hold_q + CW'(1);
          end
        end
        FALL: begin
          height_d = height_q - HW'(1);
          if (height_d == '0) state_d = GROUND;
        end
        default: begin
          state_d  = GROUND;
          height_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= GROUND;
      height_q    <= '0;
      hold_q      <= '0;
      count_q     <= '0;
      pending_q   <= 1'b0;
      div_q       <= '0;
      meta_q      <= 1'b0;
      sync_q      <= 1'b0;
      sync_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      height_q    <= height_d;
      hold_q      <= hold_d;
      count_q     <= count_d;
      pending_q   <= pending_d;
      div_q       <= div_d;
      meta_q      <= jump_button;
      sync_q      <= meta_q;
      sync_prev_q <= sync_q;
    end
  end

  // Grid and airborne derive from the registered height so they move together.
  always_comb begin
    grid       = GRID_ONE << (int'(height_q) * COLS + DINO_COL);
    height     = height_q;
    airborne   = (height_q != '0);
    jump_count = count_q;
  end

endmodule

// File: tb/tb_dino_jump_fsm.sv
// Bench for dino_jump_fsm: vector table over three configurations plus a
// randomized run of a ROWS=3 instance against a trajectory-based model.
module tb_dino_jump_fsm;

  localparam int TD_A = 4;
  localparam int ROWS_C = 3;
  localparam int JH_C = 2;
  localparam int TD_C = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;
  logic btn_a = 1'b0, btn_b = 1'b0, btn_c = 1'b0;

  logic [15:0] grid_a;
  logic [0:0]  h_a;
  logic        air_a, tick_a;
  logic [7:0]  cnt_a;
  logic [31:0] grid_b;
  logic [1:0]  h_b;
  logic        air_b, tick_b;
  logic [7:0]  cnt_b;
  logic [23:0] grid_c;
  logic [1:0]  h_c;
  logic        air_c, tick_c;
  logic [7:0]  cnt_c;

  dino_jump_fsm #(.COLS(8), .ROWS(2), .DINO_COL(0), .JUMP_HOLD(2), .TICK_DIV(TD_A)) u_a (
    .clk(clk), .reset_n(reset_n), .jump_button(btn_a), .grid(grid_a), .height(h_a),
    .airborne(air_a), .tick(tick_a), .jump_count(cnt_a)
  );
  dino_jump_fsm #(.COLS(8), .ROWS(4), .DINO_COL(2), .JUMP_HOLD(1), .TICK_DIV(4)) u_b (
    .clk(clk), .reset_n(reset_n), .jump_button(btn_b), .grid(grid_b), .height(h_b),
    .airborne(air_b), .tick(tick_b), .jump_count(cnt_b)
  );
  dino_jump_fsm #(.COLS(8), .ROWS(ROWS_C), .DINO_COL(1), .JUMP_HOLD(JH_C), .TICK_DIV(TD_C)) u_c (
    .clk(clk), .reset_n(reset_n), .jump_button(btn_c), .grid(grid_c), .height(h_c),
    .airborne(air_c), .tick(tick_c), .jump_count(cnt_c)
  );

  typedef struct {
    bit rst;
    int dut;
    bit btn;
    int n;
    int h;
    int cnt;
  } vec_t;

  vec_t vecs[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  function automatic void add(bit rst, int dut, bit btn, int n, int h, int cnt);
    vec_t v;
    v.rst = rst; v.dut = dut; v.btn = btn; v.n = n; v.h = h; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic advance(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    btn_a = 1'b0; btn_b = 1'b0; btn_c = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic set_btn(input int d, input bit v);
    case (d)
      0: btn_a = v;
      1: btn_b = v;
      default: btn_c = v;
    endcase
  endtask

  task automatic check_dut(input int d, input int h, input int cnt);
    logic [63:0] ah, ag, aa, at, ac;
    int cols, dc, td;
    string nm;
    case (d)
      0: begin ah = 64'(h_a); ag = 64'(grid_a); aa = 64'(air_a); at = 64'(tick_a);
               ac = 64'(cnt_a); cols = 8; dc = 0; td = TD_A; nm = "a"; end
      1: begin ah = 64'(h_b); ag = 64'(grid_b); aa = 64'(air_b); at = 64'(tick_b);
               ac = 64'(cnt_b); cols = 8; dc = 2; td = 4; nm = "b"; end
      default: begin ah = 64'(h_c); ag = 64'(grid_c); aa = 64'(air_c); at = 64'(tick_c);
               ac = 64'(cnt_c); cols = 8; dc = 1; td = TD_C; nm = "c"; end
    endcase
    chk({nm, ".height"}, ah, 64'(h));
    chk({nm, ".grid"}, ag, 64'(1) << (h * cols + dc));
    chk({nm, ".airborne"}, aa, 64'(h != 0));
    chk({nm, ".tick"}, at, 64'((cyc % td) == (td - 1)));
    chk({nm, ".jump_count"}, ac, 64'(cnt));
  endtask

  // Reference model: a jump is a precomputed queue of per-tick heights.
  int m_h, m_cnt, m_div;
  bit m_pend;
  int m_q[$];
  bit seen1, seen2, seen3;

  task automatic model_reset();
    m_h = 0; m_cnt = 0; m_div = 0; m_pend = 1'b0; m_q.delete();
    seen1 = 1'b0; seen2 = 1'b0; seen3 = 1'b0;
  endtask

  task automatic model_step(input bit b);
    bit tk, e, ground, falling;
    tk = (m_div == TD_C - 1);
    m_div = tk ? 0 : m_div + 1;
    e = seen2 && !seen3;
    seen3 = seen2; seen2 = seen1; seen1 = b;
    ground = (m_q.size() == 0);
    falling = (m_h != 0) && (m_h != ROWS_C - 1) && (m_q.size() == m_h);
    if (tk && ground && (m_pend || e)) begin
      m_h = 1;
      if (m_cnt < 255) m_cnt++;
      m_pend = 1'b0;
      for (int r = 2; r <= ROWS_C - 1; r++) m_q.push_back(r);
      for (int k = 0; k < JH_C - 1; k++) m_q.push_back(ROWS_C - 1);
      for (int r = ROWS_C - 2; r >= 0; r--) m_q.push_back(r);
    end else begin
      if (tk && !ground) m_h = m_q.pop_front();
      if (e && ground) m_pend = 1'b1;
`ifdef JUMP_BUFFER_EN
      if (e && falling) m_pend = 1'b1;
`endif
    end
  endtask

  initial begin
    // dut 0: ROWS=2 basic / held / airborne / same-cycle edge
    add(1, 0, 1, 3, 0, 0);
    add(0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 4, 1, 1);
    add(0, 0, 0, 4, 0, 1);
    add(0, 0, 1, 40, 0, 2);
    add(0, 0, 0, 2, 0, 2);
    add(0, 0, 1, 3, 0, 2);
    add(0, 0, 0, 3, 1, 3);
    add(0, 0, 1, 4, 1, 3);
    add(0, 0, 0, 8, 0, 3);
    add(0, 0, 0, 1, 0, 3);
    add(0, 0, 1, 2, 0, 3);
    add(0, 0, 1, 1, 1, 4);
    add(0, 0, 0, 8, 0, 4);
    // dut 1: ROWS=4 tall jump, heights 1,2,3,2,1,0
    add(1, 1, 1, 3, 0, 0);
    add(0, 1, 0, 1, 1, 1);
    add(0, 1, 0, 4, 2, 1);
    add(0, 1, 0, 4, 3, 1);
    add(0, 1, 0, 4, 2, 1);
    add(0, 1, 0, 4, 1, 1);
    add(0, 1, 0, 4, 0, 1);
    add(0, 1, 0, 8, 0, 1);
    // dut 2: ROWS=3, press lands during FALL
    add(1, 2, 1, 3, 1, 1);
    add(0, 2, 0, 7, 2, 1);
    add(0, 2, 1, 3, 1, 1);
    add(0, 2, 0, 2, 0, 1);
`ifdef JUMP_BUFFER_EN
    add(0, 2, 0, 3, 1, 2);
`else
    add(0, 2, 0, 3, 0, 1);
`endif

    do_reset();
    check_dut(0, 0, 0);
    check_dut(1, 0, 0);
    check_dut(2, 0, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      set_btn(vecs[i].dut, vecs[i].btn);
      advance(vecs[i].n);
      check_dut(vecs[i].dut, vecs[i].h, vecs[i].cnt);
    end

    // Asynchronous reset while in HOLD.
    do_reset();
    btn_a = 1'b1;
    advance(3);
    btn_a = 1'b0;
    advance(3);
    chk("hold.height_before_reset", 64'(h_a), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("reset.async_grid", 64'(grid_a), 64'h1);
    chk("reset.async_height", 64'(h_a), 64'd0);
    chk("reset.async_airborne", 64'(air_a), 64'd0);
    chk("reset.async_count", 64'(cnt_a), 64'd0);
    chk("reset.async_tick", 64'(tick_a), 64'd0);

    // Randomized run on dut 2 against the model.
    do_reset();
    model_reset();
    begin
      int run;
      bit lvl;
      run = 0;
      lvl = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        chk("rand.height", 64'(h_c), 64'(m_h));
        chk("rand.grid", 64'(grid_c), 64'(1) << (m_h * 8 + 1));
        chk("rand.airborne", 64'(air_c), 64'(m_h != 0));
        chk("rand.tick", 64'(tick_c), 64'(m_div == TD_C - 1));
        chk("rand.jump_count", 64'(cnt_c), 64'(m_cnt));
        if (run == 0) begin
          lvl = 1'($urandom_range(0, 1));
          run = $urandom_range(1, 10);
        end
        run--;
        btn_c = lvl;
        @(posedge clk);
        model_step(btn_c);
        @(negedge clk);
        cyc++;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
